// File: rtl/game_flow_ctrl.sv
// Game-flow sequencer: menu/play/win/lose/return states, end-screen frame timer and tallies.
// Optional click-to-skip of the end screen is enabled by defining GAME_CLICK_SKIP_EN.
module game_flow_ctrl #(
  parameter int unsigned END_FRAMES      = 300,
  parameter int unsigned SKIP_MIN_FRAMES = 60
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       vsync_in,
  input  logic       start_game,
  input  logic       player_dead,
  input  logic       enemy_dead,
  input  logic       mouse_left,
  output logic       select,
  output logic [1:0] game_end,
  output logic       back_to_menu,
  output logic [9:0] end_frame_cnt,
  output logic [7:0] wins,
  output logic [7:0] losses
);

  localparam logic [2:0] StMenu   = 3'd0;
  localparam logic [2:0] StPlay   = 3'd1;
  localparam logic [2:0] StWin    = 3'd2;
  localparam logic [2:0] StLose   = 3'd3;
  localparam logic [2:0] StReturn = 3'd4;

  localparam logic [9:0] EndCnt  = END_FRAMES[9:0];
  localparam logic [9:0] SkipCnt = SKIP_MIN_FRAMES[9:0];

  logic [2:0] state_q, state_d;
  logic [9:0] cnt_q, cnt_d, cnt_inc;
  logic [7:0] wins_q, wins_d, losses_q, losses_d;
  logic       vsync_q;
  logic       tick;
  logic       skip;

  assign tick    = vsync_in & ~vsync_q;
  assign cnt_inc = (cnt_q == 10'd1023) ? cnt_q : cnt_q + 10'd1;

`ifdef GAME_CLICK_SKIP_EN
  logic mouse_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) mouse_q <= 1'b0;
    else        mouse_q <= mouse_left;
  end

  assign skip = mouse_left & ~mouse_q & (cnt_q >= SkipCnt);
`else
  logic unused_mouse;
  assign unused_mouse = mouse_left;
  assign skip         = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    wins_d   = wins_q;
    losses_d = losses_q;
    case (state_q)
      StMenu: begin
        if (start_game) state_d = StPlay;
      end
      StPlay: begin
        // Player death wins the tie against enemy death.
        if (player_dead) begin
          state_d  = StLose;
          cnt_d    = 10'd0;
          losses_d = (losses_q == 8'hff) ? losses_q : losses_q + 8'd1;
        end else if (enemy_dead) begin
          state_d = StWin;
          cnt_d   = 10'd0;
          wins_d  = (wins_q == 8'hff) ? wins_q : wins_q + 8'd1;
        end
      end
      StWin, StLose: begin
        if (tick) cnt_d = cnt_inc;
        if ((tick && cnt_inc == EndCnt) || skip) state_d = StReturn;
      end
      StReturn: state_d = StMenu;
      default:  state_d = StMenu;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StMenu;
      cnt_q    <= 10'd0;
      wins_q   <= 8'd0;
      losses_q <= 8'd0;
      vsync_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      wins_q   <= wins_d;
      losses_q <= losses_d;
      vsync_q  <= vsync_in;
    end
  end

  // Outputs decode only registered state, so no input reaches them combinationally.
  assign select        = (state_q == StPlay) || (state_q == StWin) || (state_q == StLose);
  assign game_end      = (state_q == StWin) ? 2'd1 : (state_q == StLose) ? 2'd2 : 2'd0;
  assign back_to_menu  = (state_q == StReturn);
  assign end_frame_cnt = cnt_q;
  assign wins          = wins_q;
  assign losses        = losses_q;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Self-checking bench for game_flow_ctrl: per-cycle behavioural model plus directed literal checks.
module tb_game_flow_ctrl;

  localparam int EF = 3;
  localparam int SK = 2;
`ifdef GAME_CLICK_SKIP_EN
  localparam bit SkipOn = 1'b1;
`else
  localparam bit SkipOn = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       vsync_in = 1'b0, start_game = 1'b0, player_dead = 1'b0;
  logic       enemy_dead = 1'b0, mouse_left = 1'b0;
  logic       select, back_to_menu;
  logic [1:0] game_end;
  logic [9:0] end_frame_cnt;
  logic [7:0] wins, losses;

  int checks = 0;
  int passed = 0;

  game_flow_ctrl #(.END_FRAMES(EF), .SKIP_MIN_FRAMES(SK)) dut (
    .clk(clk), .rst_n(rst_n), .vsync_in(vsync_in), .start_game(start_game),
    .player_dead(player_dead), .enemy_dead(enemy_dead), .mouse_left(mouse_left),
    .select(select), .game_end(game_end), .back_to_menu(back_to_menu),
    .end_frame_cnt(end_frame_cnt), .wins(wins), .losses(losses)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Model: phase 0 menu, 1 play, 2 win, 3 lose, 4 return-pulse cycle.
  int m_ph, m_cnt, m_w, m_l, nc;
  bit m_vs, m_ms, tk, ck;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ph <= 0; m_cnt <= 0; m_w <= 0; m_l <= 0; m_vs <= 0; m_ms <= 0;
    end else begin
      tk = vsync_in && !m_vs;
      ck = mouse_left && !m_ms;
      m_vs <= vsync_in;
      m_ms <= mouse_left;
      if (m_ph == 0 && start_game) m_ph <= 1;
      else if (m_ph == 1 && player_dead) begin
        m_ph <= 3; m_cnt <= 0; m_l <= (m_l < 255) ? m_l + 1 : 255;
      end else if (m_ph == 1 && enemy_dead) begin
        m_ph <= 2; m_cnt <= 0; m_w <= (m_w < 255) ? m_w + 1 : 255;
      end else if (m_ph == 2 || m_ph == 3) begin
        nc = tk ? ((m_cnt < 1023) ? m_cnt + 1 : 1023) : m_cnt;
        m_cnt <= nc;
        if ((tk && nc == EF) || (SkipOn && ck && m_cnt >= SK)) m_ph <= 4;
      end else if (m_ph == 4) m_ph <= 0;
    end
  end

  always @(posedge clk) begin
    #1;
    if (rst_n) begin
      check("model_select", int'(select), int'(m_ph >= 1 && m_ph <= 3));
      check("model_game_end", int'(game_end), (m_ph == 2) ? 1 : (m_ph == 3) ? 2 : 0);
      check("model_back_to_menu", int'(back_to_menu), int'(m_ph == 4));
      check("model_cnt", int'(end_frame_cnt), m_cnt);
      check("model_wins", int'(wins), m_w);
      check("model_losses", int'(losses), m_l);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start();
    start_game = 1'b1; cyc(1); start_game = 1'b0;
  endtask

  task automatic vs_pulse();
    vsync_in = 1'b1; cyc(2); vsync_in = 1'b0; cyc(1);
  endtask

  task automatic count_btm(input int n, output int c);
    c = 0;
    repeat (n) begin
      @(posedge clk); #1;
      c += int'(back_to_menu);
    end
    @(negedge clk);
  endtask

  task automatic finish_end_screen();
    for (int i = 0; i < 10 && select; i++) vs_pulse();
    cyc(2);
  endtask

  int c;

  initial begin
    cyc(2);
    check("reset_select", int'(select), 0);
    check("reset_game_end", int'(game_end), 0);
    check("reset_wins", int'(wins), 0);
    rst_n = 1'b1;
    cyc(2);

    // Win path with vsync held high to prove one count per frame.
    pulse_start();
    check("start_select", int'(select), 1);
    enemy_dead = 1'b1; cyc(1); enemy_dead = 1'b0;
    check("win_game_end", int'(game_end), 1);
    check("win_wins", int'(wins), 1);
    check("win_cnt_cleared", int'(end_frame_cnt), 0);
    vsync_in = 1'b1; cyc(20);
    check("held_vsync_cnt", int'(end_frame_cnt), 1);
    vsync_in = 1'b0; cyc(1);
    vs_pulse();
    check("second_tick_cnt", int'(end_frame_cnt), 2);
    vsync_in = 1'b1;
    count_btm(5, c);
    vsync_in = 1'b0;
    check("win_btm_pulses", c, 1);
    check("after_return_select", int'(select), 0);
    check("after_return_cnt", int'(end_frame_cnt), 3);

    // Both dead: lose has priority.
    pulse_start();
    player_dead = 1'b1; enemy_dead = 1'b1; cyc(1);
    player_dead = 1'b0; enemy_dead = 1'b0;
    check("tie_game_end", int'(game_end), 2);
    check("tie_losses", int'(losses), 1);
    check("tie_wins", int'(wins), 1);
    finish_end_screen();
    check("lose_return_select", int'(select), 0);

    // Dead flags in menu are ignored.
    player_dead = 1'b1; enemy_dead = 1'b1; cyc(5);
    player_dead = 1'b0; enemy_dead = 1'b0;
    check("menu_dead_select", int'(select), 0);
    check("menu_dead_losses", int'(losses), 1);

    // Click skip: too early at 1, allowed at 2 only when the feature is built in.
    pulse_start();
    enemy_dead = 1'b1; cyc(1); enemy_dead = 1'b0;
    vs_pulse();
    check("skip_cnt1", int'(end_frame_cnt), 1);
    mouse_left = 1'b1;
    count_btm(4, c);
    mouse_left = 1'b0;
    check("early_click_btm", c, 0);
    vs_pulse();
    check("skip_cnt2", int'(end_frame_cnt), 2);
    mouse_left = 1'b1;
    count_btm(4, c);
    mouse_left = 1'b0;
    check("click_btm", c, SkipOn ? 1 : 0);
    check("click_select", int'(select), SkipOn ? 0 : 1);
    finish_end_screen();

    // Asynchronous reset mid-play, observed away from any clock edge.
    pulse_start();
    #2 rst_n = 1'b0;
    #1;
    check("async_select", int'(select), 0);
    check("async_wins", int'(wins), 0);
    check("async_losses", int'(losses), 0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc(2);

    // Win tally saturation.
    for (int g = 0; g < 256; g++) begin
      pulse_start();
      enemy_dead = 1'b1; cyc(1); enemy_dead = 1'b0;
      for (int k = 0; k < EF; k++) vs_pulse();
      cyc(2);
    end
    check("sat_wins", int'(wins), 255);
    check("sat_losses", int'(losses), 0);
    check("sat_select", int'(select), 0);

    cyc(2);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

endmodule
